// File: rtl/reshape_permute_if.sv
// Handshake bundle for reshape_permute_unit: the input row stream, the output row stream,
// mode select and status.
interface reshape_permute_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8
);
  logic [1:0]              cfg_mode;
  logic [N*DATA_WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;
  logic                    busy;
  logic                    mode_err;

  modport master (
    output cfg_mode, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, mode_err
  );

  modport slave (
    input  cfg_mode, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, mode_err
  );
endinterface

// File: rtl/reshape_permute_unit.sv
// Streaming N x N tile reshaper: loads N row beats, then replays them as pass, transpose or
// lane-reverse. Define RESHAPE_PAD_EN to allow short tiles ended by in_last (missing rows read as 0).
module reshape_permute_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  reshape_permute_if.slave  bus
);
  localparam int IDX_W = $clog2(N);
  localparam int ROW_W = N * DATA_WIDTH;

  typedef enum logic {LOAD, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic [1:0]             mode_q, mode_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   mode_err_q, mode_err_d;
`ifdef RESHAPE_PAD_EN
  logic [IDX_W:0]         rows_loaded_q, rows_loaded_d;
`endif

  logic [ROW_W-1:0]       tile_q [N];
  logic                   in_fire, out_fire, last_in_beat;
  logic [ROW_W-1:0]       row_perm;
  logic [IDX_W-1:0]       src_row, src_lane;
  logic [DATA_WIDTH-1:0]  elem;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

`ifdef RESHAPE_PAD_EN
  assign last_in_beat = (wr_idx_q == IDX_W'(N-1)) || bus.in_last;
`else
  assign last_in_beat = (wr_idx_q == IDX_W'(N-1));
`endif

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    mode_d     = mode_q;
    mode_err_d = 1'b0;
`ifdef RESHAPE_PAD_EN
    rows_loaded_d = rows_loaded_q;
`endif
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          // Mode is fixed per tile from its first beat; reserved mode falls back to pass.
          if (wr_idx_q == '0) begin
            mode_d     = (bus.cfg_mode == 2'd3) ? 2'd0 : bus.cfg_mode;
            mode_err_d = (bus.cfg_mode == 2'd3);
          end
          if (last_in_beat) begin
            state_d  = DRAIN;
            wr_idx_d = '0;
`ifdef RESHAPE_PAD_EN
            rows_loaded_d = {1'b0, wr_idx_q} + (IDX_W+1)'(1);
`endif
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (rd_idx_q == IDX_W'(N-1)) begin
            state_d  = LOAD;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && (rd_idx_d == IDX_W'(N-1));
    busy_d      = (state_d == DRAIN) || (wr_idx_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      mode_q      <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      mode_err_q  <= 1'b0;
`ifdef RESHAPE_PAD_EN
      rows_loaded_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      mode_err_q  <= mode_err_d;
`ifdef RESHAPE_PAD_EN
      rows_loaded_q <= rows_loaded_d;
`endif
    end
  end

  // Tile storage is data only; stale rows are never visible because output is gated by state.
  always_ff @(posedge clk) begin
    if (in_fire) tile_q[wr_idx_q] <= bus.in_data;
  end

  always_comb begin
    row_perm = '0;
    src_row  = '0;
    src_lane = '0;
    elem     = '0;
    for (int i = 0; i < N; i++) begin
      src_row  = rd_idx_q;
      src_lane = IDX_W'(i);
      case (mode_q)
        2'd1: begin
          src_row  = IDX_W'(i);
          src_lane = rd_idx_q;
        end
        2'd2:    src_lane = IDX_W'(N-1-i);
        default: ;
      endcase
      elem = tile_q[src_row][int'(src_lane)*DATA_WIDTH +: DATA_WIDTH];
`ifdef RESHAPE_PAD_EN
      if ({1'b0, src_row} >= rows_loaded_q) elem = '0;
`endif
      row_perm[i*DATA_WIDTH +: DATA_WIDTH] = elem;
    end
  end

  assign bus.out_data  = out_valid_q ? row_perm : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.mode_err  = mode_err_q;
endmodule
